id_ex_stage: RTL and testbench

- ID/EX pipeline stage directly upstream of the ALU.
- Registers decoded operands and control from the decode stage.
- Applies EX/MEM and MEM/WB operand forwarding and drives the ALU's A, B and alu_ctrl inputs.
- Detects load-use hazards, inserts bubbles, and honours external stall and flush.

---
 rtl/id_ex_stage.sv | 179 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use bubble insertion, external stall/flush and illegal ALU op flagging.
module id_ex_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_use_imm,
    input  logic              id_use_rs2,
    input  logic [3:0]        id_alu_ctrl,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_we,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_we,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_we,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_ctrl,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_we,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_illegal,
    output logic              load_use_stall
);

    localparam int unsigned CTRL_W = 4;

    logic              valid_q,    valid_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [REG_AW-1:0] rs1_q,      rs1_d;
    logic [REG_AW-1:0] rs2_q,      rs2_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q,      imm_d;
    logic              use_imm_q,  use_imm_d;
    logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic              reg_we_q,   reg_we_d;
    logic              mem_rd_q,   mem_rd_d;
    logic              mem_wr_q,   mem_wr_d;
    logic              illegal_q,  illegal_d;

    logic              id_legal;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;

    always_comb begin
        id_legal = id_alu_ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                       4'b1000, 4'b1001, 4'b1010};
    end

    // Load in EX whose destination is read by the instruction now in decode.
    assign load_use_stall = valid_q && mem_rd_q && (rd_q != '0) && id_valid &&
                            ((id_rs1 == rd_q) || (id_use_rs2 && (id_rs2 == rd_q)));

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        use_imm_d  = use_imm_q;
        ctrl_d     = ctrl_q;
        rd_d       = rd_q;
        reg_we_d   = reg_we_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        illegal_d  = illegal_q;
        if (flush || (!stall && load_use_stall)) begin
            valid_d   = 1'b0;
            reg_we_d  = 1'b0;
            mem_rd_d  = 1'b0;
            mem_wr_d  = 1'b0;
            illegal_d = 1'b0;
        end else if (!stall) begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            use_imm_d  = id_use_imm;
            ctrl_d     = id_alu_ctrl;
            rd_d       = id_rd;
            reg_we_d   = id_reg_we && id_valid && id_legal;
            mem_rd_d   = id_mem_rd && id_valid && id_legal;
            mem_wr_d   = id_mem_wr && id_valid && id_legal;
            illegal_d  = id_valid && !id_legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            reg_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            use_imm_q  <= use_imm_d;
            ctrl_q     <= ctrl_d;
            rd_q       <= rd_d;
            reg_we_q   <= reg_we_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            illegal_q  <= illegal_d;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB; x0 is never forwarded.
    always_comb begin
        src1 = rs1_data_q;
        if (exmem_reg_we && (exmem_rd != '0) && (exmem_rd == rs1_q)) begin
            src1 = exmem_result;
        end else if (memwb_reg_we && (memwb_rd != '0) && (memwb_rd == rs1_q)) begin
            src1 = memwb_result;
        end
    end

    always_comb begin
        src2 = rs2_data_q;
        if (exmem_reg_we && (exmem_rd != '0) && (exmem_rd == rs2_q)) begin
            src2 = exmem_result;
        end else if (memwb_reg_we && (memwb_rd != '0) && (memwb_rd == rs2_q)) begin
            src2 = memwb_result;
        end
    end

    assign ex_valid      = valid_q;
    assign alu_a         = src1;
    assign alu_b         = use_imm_q ? imm_q : src2;
    assign alu_ctrl      = ctrl_q;
    assign ex_pc         = pc_q;
    assign ex_store_data = src2;
    assign ex_rd         = rd_q;
    assign ex_reg_we     = reg_we_q && valid_q;
    assign ex_mem_rd     = mem_rd_q && valid_q;
    assign ex_mem_wr     = mem_wr_q && valid_q;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes reference-model expectations,
// an independent monitor samples the DUT each cycle and compares.
module tb_id_ex_stage;

    typedef struct {
        logic        id_valid;
        logic [31:0] id_pc;
        logic [4:0]  id_rs1, id_rs2;
        logic [31:0] id_rs1_data, id_rs2_data, id_imm;
        logic        id_use_imm, id_use_rs2;
        logic [3:0]  id_alu_ctrl;
        logic [4:0]  id_rd;
        logic        id_reg_we, id_mem_rd, id_mem_wr;
        logic        stall, flush;
        logic [4:0]  exmem_rd;
        logic        exmem_reg_we;
        logic [31:0] exmem_result;
        logic [4:0]  memwb_rd;
        logic        memwb_reg_we;
        logic [31:0] memwb_result;
    } stim_t;

    // Instruction currently sitting in EX, as the model sees it.
    typedef struct {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        use_imm;
        logic [3:0]  ctrl;
        logic        we, mrd, mwr, ill;
    } model_t;

    typedef struct {
        logic        ex_valid;
        logic [31:0] alu_a, alu_b, ex_pc, store;
        logic [3:0]  alu_ctrl;
        logic [4:0]  ex_rd;
        logic        we, mrd, mwr, ill, lus;
    } exp_t;

    localparam logic [3:0] LEGAL [7] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h9, 4'hA};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic        id_valid, id_use_imm, id_use_rs2, id_reg_we, id_mem_rd, id_mem_wr;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
    logic [3:0]  id_alu_ctrl;
    logic        stall, flush, exmem_reg_we, memwb_reg_we;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal, load_use_stall;
    logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd;

    int total = 0;
    int bad = 0;
    exp_t   exp_q[$];
    stim_t  cur;
    model_t m;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_use_rs2(id_use_rs2), .id_alu_ctrl(id_alu_ctrl),
        .id_rd(id_rd), .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .stall(stall), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_reg_we(exmem_reg_we), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_we(memwb_reg_we), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_illegal(ex_illegal), .load_use_stall(load_use_stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Value an instruction would see for register r, given the newer stages.
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] stored);
        if (cur.exmem_reg_we && cur.exmem_rd != 0 && cur.exmem_rd == r) return cur.exmem_result;
        if (cur.memwb_reg_we && cur.memwb_rd != 0 && cur.memwb_rd == r) return cur.memwb_result;
        return stored;
    endfunction

    function automatic logic model_lus();
        logic reads;
        reads = (cur.id_rs1 == m.rd) || (cur.id_use_rs2 && cur.id_rs2 == m.rd);
        return m.valid && m.mrd && m.rd != 0 && cur.id_valid && reads;
    endfunction

    task automatic model_reset();
        m = '{default: '0};
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        cur = s;
        id_valid = s.id_valid; id_pc = s.id_pc; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
        id_rs1_data = s.id_rs1_data; id_rs2_data = s.id_rs2_data; id_imm = s.id_imm;
        id_use_imm = s.id_use_imm; id_use_rs2 = s.id_use_rs2; id_alu_ctrl = s.id_alu_ctrl;
        id_rd = s.id_rd; id_reg_we = s.id_reg_we; id_mem_rd = s.id_mem_rd; id_mem_wr = s.id_mem_wr;
        stall = s.stall; flush = s.flush;
        exmem_rd = s.exmem_rd; exmem_reg_we = s.exmem_reg_we; exmem_result = s.exmem_result;
        memwb_rd = s.memwb_rd; memwb_reg_we = s.memwb_reg_we; memwb_result = s.memwb_result;
        #1;
        e.ex_valid = m.valid;
        e.alu_a    = fwd(m.rs1, m.d1);
        e.store    = fwd(m.rs2, m.d2);
        e.alu_b    = m.use_imm ? m.imm : e.store;
        e.alu_ctrl = m.ctrl;
        e.ex_pc    = m.pc;
        e.ex_rd    = m.rd;
        e.we       = m.valid && m.we;
        e.mrd      = m.valid && m.mrd;
        e.mwr      = m.valid && m.mwr;
        e.ill      = m.ill;
        e.lus      = model_lus();
        exp_q.push_back(e);
    endtask

    task automatic tick();
        logic lus, legal;
        lus = model_lus();
        @(posedge clk);
        legal = cur.id_alu_ctrl inside {LEGAL};
        if (cur.flush || (!cur.stall && lus)) begin
            m.valid = 0; m.we = 0; m.mrd = 0; m.mwr = 0; m.ill = 0;
        end else if (!cur.stall) begin
            m.valid = cur.id_valid;   m.pc = cur.id_pc;
            m.rs1 = cur.id_rs1;       m.rs2 = cur.id_rs2;
            m.d1 = cur.id_rs1_data;   m.d2 = cur.id_rs2_data;
            m.imm = cur.id_imm;       m.use_imm = cur.id_use_imm;
            m.ctrl = cur.id_alu_ctrl; m.rd = cur.id_rd;
            m.we  = cur.id_valid && legal && cur.id_reg_we;
            m.mrd = cur.id_valid && legal && cur.id_mem_rd;
            m.mwr = cur.id_valid && legal && cur.id_mem_wr;
            m.ill = cur.id_valid && !legal;
        end
    endtask

    task automatic step(input stim_t s);
        apply(s);
        tick();
    endtask

    // Monitor: compares every DUT output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ex_valid",       32'(ex_valid),       32'(e.ex_valid));
                check("alu_a",          alu_a,               e.alu_a);
                check("alu_b",          alu_b,               e.alu_b);
                check("alu_ctrl",       32'(alu_ctrl),       32'(e.alu_ctrl));
                check("ex_pc",          ex_pc,               e.ex_pc);
                check("ex_store_data",  ex_store_data,       e.store);
                check("ex_rd",          32'(ex_rd),          32'(e.ex_rd));
                check("ex_reg_we",      32'(ex_reg_we),      32'(e.we));
                check("ex_mem_rd",      32'(ex_mem_rd),      32'(e.mrd));
                check("ex_mem_wr",      32'(ex_mem_wr),      32'(e.mwr));
                check("ex_illegal",     32'(ex_illegal),     32'(e.ill));
                check("load_use_stall", 32'(load_use_stall), 32'(e.lus));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        model_reset();
        cur = idle();
        {id_valid, id_use_imm, id_use_rs2, id_reg_we, id_mem_rd, id_mem_wr} = '0;
        {id_pc, id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result} = '0;
        {id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd, id_alu_ctrl} = '0;
        {stall, flush, exmem_reg_we, memwb_reg_we} = '0;
        #12;
        check("reset_ex_valid", 32'(ex_valid), 0);
        check("reset_alu_ctrl", 32'(alu_ctrl), 0);
        check("reset_ex_pc", ex_pc, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_illegal", 32'(ex_illegal), 0);
        #1 rst_n = 1'b1;

        // ADD x3, x1, x2
        s = idle(); s.id_valid = 1; s.id_pc = 32'h100; s.id_rs1 = 1; s.id_rs2 = 2;
        s.id_rs1_data = 5; s.id_rs2_data = 7; s.id_use_rs2 = 1; s.id_rd = 3; s.id_reg_we = 1;
        step(s);
        s.stall = 1;
        apply(s);
        check("add_valid", 32'(ex_valid), 1);
        check("add_a", alu_a, 5);
        check("add_b", alu_b, 7);
        check("add_rd", 32'(ex_rd), 3);
        check("add_we", 32'(ex_reg_we), 1);
        tick();

        // Forwarding priority on stored rs1=x1 while held by stall
        s.exmem_rd = 1; s.exmem_reg_we = 1; s.exmem_result = 32'h10;
        s.memwb_rd = 1; s.memwb_reg_we = 1; s.memwb_result = 32'h20;
        apply(s); check("fwd_exmem", alu_a, 32'h10); tick();
        s.exmem_reg_we = 0;
        apply(s); check("fwd_memwb", alu_a, 32'h20); tick();
        s.exmem_rd = 0; s.exmem_reg_we = 1; s.memwb_reg_we = 0;
        apply(s); check("fwd_x0", alu_a, 5); tick();

        // Load in EX followed by consumer of rs2
        s = idle(); s.id_valid = 1; s.id_alu_ctrl = 0; s.id_rd = 4; s.id_mem_rd = 1;
        s.id_reg_we = 1; s.id_use_imm = 1; s.id_imm = 8;
        step(s);
        s = idle(); s.id_valid = 1; s.id_rs2 = 4; s.id_use_rs2 = 1; s.id_rd = 6; s.id_reg_we = 1;
        apply(s); check("lus_set", 32'(load_use_stall), 1); tick();
        apply(idle()); check("bubble_valid", 32'(ex_valid), 0);
        check("bubble_we", 32'(ex_reg_we), 0); check("bubble_mrd", 32'(ex_mem_rd), 0); tick();
        s = idle(); s.id_valid = 1; s.id_rd = 4; s.id_mem_rd = 1; s.id_reg_we = 1; s.id_use_imm = 1;
        step(s);
        s = idle(); s.id_valid = 1; s.id_rs2 = 4; s.id_use_imm = 1; s.id_rs1 = 0;
        apply(s); check("lus_imm_clear", 32'(load_use_stall), 0); tick();

        // SUB held by a 3-cycle stall, forwarded value moving underneath
        s = idle(); s.id_valid = 1; s.id_alu_ctrl = 4'h1; s.id_rs1 = 9; s.id_rs2 = 10;
        s.id_rs1_data = 100; s.id_rs2_data = 30; s.id_rd = 11; s.id_reg_we = 1; s.id_pc = 32'h200;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.stall = 1; s.id_valid = 1; s.id_alu_ctrl = 4'h2; s.id_rd = 12;
            s.exmem_rd = 9; s.exmem_reg_we = 1; s.exmem_result = 32'(1000 + i);
            apply(s); check("stall_fwd_a", alu_a, 32'(1000 + i));
            check("stall_ctrl", 32'(alu_ctrl), 1); tick();
        end

        // flush beats stall
        s = idle(); s.stall = 1; s.flush = 1; s.id_valid = 1; s.id_reg_we = 1;
        step(s);
        apply(idle()); check("flush_valid", 32'(ex_valid), 0); tick();

        // Illegal op 0011
        s = idle(); s.id_valid = 1; s.id_alu_ctrl = 4'h3; s.id_reg_we = 1; s.id_rd = 5;
        step(s);
        apply(idle()); check("illegal_flag", 32'(ex_illegal), 1);
        check("illegal_we", 32'(ex_reg_we), 0); tick();

        // Asynchronous reset with a valid instruction in EX
        s = idle(); s.id_valid = 1; s.id_pc = 32'h300; s.id_rs1_data = 77; s.id_reg_we = 1;
        s.id_alu_ctrl = 4'h8; s.id_rd = 7;
        step(s);
        #3;
        check("pre_reset_valid", 32'(ex_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ex_valid), 0);
        check("async_rst_pc", ex_pc, 0);
        check("async_rst_we", 32'(ex_reg_we), 0);
        check("async_rst_a", alu_a, 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Randomized traffic with small register indices to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            s.id_valid     = ($urandom_range(0, 9) != 0);
            s.id_pc        = $urandom;
            s.id_rs1       = 5'($urandom_range(0, 7));
            s.id_rs2       = 5'($urandom_range(0, 7));
            s.id_rs1_data  = $urandom;
            s.id_rs2_data  = $urandom;
            s.id_imm       = $urandom;
            s.id_use_imm   = 1'($urandom_range(0, 1));
            s.id_use_rs2   = 1'($urandom_range(0, 1));
            s.id_alu_ctrl  = ($urandom_range(0, 4) != 0) ? LEGAL[$urandom_range(0, 6)]
                                                         : 4'($urandom_range(0, 15));
            s.id_rd        = 5'($urandom_range(0, 7));
            s.id_reg_we    = 1'($urandom_range(0, 1));
            s.id_mem_rd    = ($urandom_range(0, 2) == 0);
            s.id_mem_wr    = ($urandom_range(0, 3) == 0);
            s.stall        = ($urandom_range(0, 7) == 0);
            s.flush        = ($urandom_range(0, 15) == 0);
            s.exmem_rd     = 5'($urandom_range(0, 7));
            s.exmem_reg_we = 1'($urandom_range(0, 1));
            s.exmem_result = $urandom;
            s.memwb_rd     = 5'($urandom_range(0, 7));
            s.memwb_reg_we = 1'($urandom_range(0, 1));
            s.memwb_result = $urandom;
            step(s);
        end

        repeat (3) @(negedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
